checksum_verify: RTL

Receive-side checker for the 8-bit one's-complement frame checksum.
- Consumes a byte stream framed as four data bytes plus one checksum byte, and reassembles the 32-bit data word.
- Recomputes the end-around-carry sum and flags the frame good or bad.
- Sits directly downstream of the checksum generator / link, and presents one result word per frame to the consumer through a valid/ready handshake.

---
 rtl/checksum_pkg.sv | 23 ++
 rtl/checksum_verify_if.sv | 26 ++
 rtl/checksum_verify_sat_counter.sv | 19 +
 rtl/checksum_verify.sv | 129 ++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// Shared definitions for the one's-complement frame checksum generator and checker.
// Holds the FSM state type, frame geometry and the end-around-carry adder.
package checksum_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    DISCARD,
    HOLD
  } state_t;

  localparam int          FRAME_BYTES = 5;
  localparam logic [7:0]  CSUM_GOOD   = 8'hFF;
  localparam logic [2:0]  LAST_IDX    = 3'(FRAME_BYTES - 1);

  // One's-complement add: fold the carry out of bit 7 back into bit 0.
  // The fold cannot carry again because t[7:0] is at most 8'hFE when t[8] is set.
  function automatic logic [7:0] csum_add8(input logic [7:0] acc, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, acc} + {1'b0, b};
    return t[7:0] + {7'b0, t[8]};
  endfunction

endpackage

// File: rtl/checksum_verify_if.sv
// Byte-stream input and result output of the checksum checker, both valid/ready.
// slave is the checker's view, master is the link/consumer side.
interface checksum_verify_if;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ok;
  logic        out_len_err;

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ok, out_len_err
  );

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ok, out_len_err
  );

endinterface

// File: rtl/checksum_verify_sat_counter.sv
// Event counter that increments on inc and then sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/checksum_verify.sv
// Receive-side checker: reassembles four data bytes, verifies the one's-complement
// checksum byte and hands one result word per frame to the consumer.
module checksum_verify
  import checksum_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  checksum_verify_if.slave bus,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad
);

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  acc;
  logic [31:0] data_q;
  logic        ok_q;
  logic        len_err_q;
  logic        valid_q;

  logic        in_ready;
  logic        byte_fire;
  logic [7:0]  sum_next;
  logic        enter_hold;
  logic        frame_ok;

  assign in_ready = (state != HOLD);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_fire  = 1'b0;
    sum_next   = 8'h00;
    enter_hold = 1'b0;
    frame_ok   = 1'b0;

    byte_fire  = bus.in_valid && in_ready;
    sum_next   = csum_add8(acc, bus.in_byte);
    enter_hold = byte_fire && bus.in_last;
    // Only a correctly sized frame ending in COLLECT can be good; DISCARD always ends bad.
    frame_ok   = (state == COLLECT) && (idx == LAST_IDX) && (sum_next == CSUM_GOOD);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= 3'd0;
      acc       <= 8'h00;
      data_q    <= 32'h0;
      ok_q      <= 1'b0;
      len_err_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (byte_fire) begin
            acc <= sum_next;
            if (idx != LAST_IDX) begin
              data_q[{idx[1:0], 3'b000} +: 8] <= bus.in_byte;
            end
            if (idx == LAST_IDX) begin
              if (bus.in_last) begin
                ok_q      <= frame_ok;
                len_err_q <= 1'b0;
                valid_q   <= 1'b1;
                state     <= HOLD;
              end else begin
                // Too long: latch the error now, swallow bytes until in_last.
                ok_q      <= 1'b0;
                len_err_q <= 1'b1;
                state     <= DISCARD;
              end
            end else if (bus.in_last) begin
              ok_q      <= 1'b0;
              len_err_q <= 1'b1;
              valid_q   <= 1'b1;
              state     <= HOLD;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        DISCARD: begin
          if (enter_hold) begin
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end

        HOLD: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            idx     <= 3'd0;
            acc     <= 8'h00;
            data_q  <= 32'h0;
            state   <= COLLECT;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_ok      = ok_q;
  assign bus.out_len_err = len_err_q;

  // Counters step on the same edge that enters HOLD, once per frame.
  sat_counter #(.WIDTH(CNT_W)) u_cnt_good (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enter_hold && frame_ok),
    .count (cnt_good)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_bad (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enter_hold && !frame_ok),
    .count (cnt_bad)
  );

endmodule
